// File: rtl/imem_arbiter.sv
// imem_arbiter
//   Shares the single-port, synchronous-read instruction memory between the
//   CPU fetch stage (port F, read-only) and the program loader/debug port
//   (port L, read/write). At most one request is granted per cycle; the read
//   response (or write ack) returns exactly one cycle after acceptance and is
//   steered to the requester that owns it.
//
//   Arbitration: L wins ties unless F has lost STARVE_LIMIT consecutive
//   arbitrations, in which case the pending fetch is forced through.
//
// Ports
//   clk, reset            clock (rising edge), async active-high reset
//   f_req_valid/_ready    fetch request handshake, f_addr word address
//   f_flush               kills the fetch in flight and blocks new fetch grants
//   f_rsp_valid/_data     fetch response (data is m_rdata passed through)
//   l_req_valid/_ready    loader request handshake, l_we/l_addr/l_wdata
//   l_rsp_valid/_data     loader read data or write ack (data 0)
//   m_en/m_we/m_addr/m_wdata  memory request, m_rdata valid the cycle after m_en
//
// Build option
//   IMEM_ARB_PERF_EN      adds perf_clr input and the perf_f_grants,
//                         perf_l_grants, perf_f_stall wrapping counters.

module imem_arbiter #(
  parameter int MEM_ADDR_WIDTH = 10,
  parameter int INST_WIDTH     = 32,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      f_req_valid,
  output logic                      f_req_ready,
  input  logic [MEM_ADDR_WIDTH-1:0] f_addr,
  input  logic                      f_flush,
  output logic                      f_rsp_valid,
  output logic [INST_WIDTH-1:0]     f_rsp_data,
  input  logic                      l_req_valid,
  output logic                      l_req_ready,
  input  logic                      l_we,
  input  logic [MEM_ADDR_WIDTH-1:0] l_addr,
  input  logic [INST_WIDTH-1:0]     l_wdata,
  output logic                      l_rsp_valid,
  output logic [INST_WIDTH-1:0]     l_rsp_data,
  output logic                      m_en,
  output logic                      m_we,
  output logic [MEM_ADDR_WIDTH-1:0] m_addr,
  output logic [INST_WIDTH-1:0]     m_wdata,
  input  logic [INST_WIDTH-1:0]     m_rdata
`ifdef IMEM_ARB_PERF_EN
  ,
  input  logic                      perf_clr,
  output logic [31:0]               perf_f_grants,
  output logic [31:0]               perf_l_grants,
  output logic [31:0]               perf_f_stall
`endif
);

  // Owner of the access currently in the memory's read pipeline.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_F    = 2'd1,
    OWN_LR   = 2'd2,
    OWN_LW   = 2'd3
  } owner_e;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  owner_e     owner_q, owner_d;
  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       grant_f, grant_l;

  // NOTE: every signal assigned in an always_comb gets a default first so no
  // path through the block leaves it unassigned (which would infer a latch).
  always_comb begin
    grant_f = 1'b0;
    grant_l = 1'b0;
    // Nothing is granted while reset is held, so no access is launched that
    // the cleared owner tag would then orphan.
    if (!reset) begin
      grant_f = f_req_valid && !f_flush &&
                (!l_req_valid || (starve_cnt_q == STARVE_MAX));
      grant_l = l_req_valid && !grant_f;
    end
  end

  assign f_req_ready = grant_f;
  assign l_req_ready = grant_l;

  always_comb begin
    m_en    = grant_f | grant_l;
    m_we    = grant_l & l_we;
    m_addr  = '0;
    m_wdata = '0;
    if (grant_f) begin
      m_addr = f_addr;
    end else if (grant_l) begin
      m_addr  = l_addr;
      m_wdata = l_wdata;
    end
  end

  always_comb begin
    owner_d      = OWN_NONE;
    starve_cnt_d = starve_cnt_q;
    if (grant_f)      owner_d = OWN_F;
    else if (grant_l) owner_d = l_we ? OWN_LW : OWN_LR;

    // A flush freezes the count; an absent fetch or a won fetch resets it.
    if (!f_flush) begin
      if (!f_req_valid || grant_f) begin
        starve_cnt_d = '0;
      end else if (grant_l && (starve_cnt_q != STARVE_MAX)) begin
        starve_cnt_d = starve_cnt_q + 4'd1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q      <= OWN_NONE;
      starve_cnt_q <= '0;
    end else begin
      owner_q      <= owner_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Flush in the cycle a fetch response lands suppresses it combinationally;
  // a flush is the kill flag, so no extra state is needed for it.
  assign f_rsp_valid = (owner_q == OWN_F) && !f_flush;
  assign f_rsp_data  = m_rdata;
  assign l_rsp_valid = (owner_q == OWN_LR) || (owner_q == OWN_LW);
  assign l_rsp_data  = (owner_q == OWN_LR) ? m_rdata : '0;

`ifdef IMEM_ARB_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_f_grants <= '0;
      perf_l_grants <= '0;
      perf_f_stall  <= '0;
    end else if (perf_clr) begin
      perf_f_grants <= '0;
      perf_l_grants <= '0;
      perf_f_stall  <= '0;
    end else begin
      if (grant_f)                  perf_f_grants <= perf_f_grants + 32'd1;
      if (grant_l)                  perf_l_grants <= perf_l_grants + 32'd1;
      if (f_req_valid && !grant_f)  perf_f_stall  <= perf_f_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter
//   Directed bench for imem_arbiter with a behavioural single-port memory.
//   Inputs change 1 ns after the rising edge; outputs are sampled 2 ns after.

module tb_imem_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          f_req_valid, f_req_ready, f_flush, f_rsp_valid;
  logic [AW-1:0] f_addr;
  logic [DW-1:0] f_rsp_data;
  logic          l_req_valid, l_req_ready, l_we, l_rsp_valid;
  logic [AW-1:0] l_addr;
  logic [DW-1:0] l_wdata, l_rsp_data;
  logic          m_en, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
`ifdef IMEM_ARB_PERF_EN
  logic          perf_clr = 1'b0;
  logic [31:0]   perf_f_grants, perf_l_grants, perf_f_stall;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  imem_arbiter #(.MEM_ADDR_WIDTH(AW), .INST_WIDTH(DW), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .f_req_valid(f_req_valid), .f_req_ready(f_req_ready), .f_addr(f_addr),
    .f_flush(f_flush), .f_rsp_valid(f_rsp_valid), .f_rsp_data(f_rsp_data),
    .l_req_valid(l_req_valid), .l_req_ready(l_req_ready), .l_we(l_we),
    .l_addr(l_addr), .l_wdata(l_wdata), .l_rsp_valid(l_rsp_valid),
    .l_rsp_data(l_rsp_data),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata)
`ifdef IMEM_ARB_PERF_EN
    , .perf_clr(perf_clr), .perf_f_grants(perf_f_grants),
    .perf_l_grants(perf_l_grants), .perf_f_stall(perf_f_stall)
`endif
  );

  // Single-port synchronous-read memory, write-first.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (m_en) begin
      if (m_we) begin
        mem[m_addr] <= m_wdata;
        m_rdata     <= m_wdata;
      end else begin
        m_rdata <= mem[m_addr];
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Advance to 1 ns after the next rising edge (input drive point).
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    f_req_valid = 1'b0; f_addr = '0; f_flush = 1'b0;
    l_req_valid = 1'b0; l_we = 1'b0; l_addr = '0; l_wdata = '0;
  endtask

  // Loader write, checking the grant now and the zero-data ack next cycle.
  task automatic l_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    l_req_valid = 1'b1; l_we = 1'b1; l_addr = a; l_wdata = d;
    #1;
    check("lw_ready", 64'(l_req_ready), 64'd1);
    tick();
    idle_inputs();
    #1;
    check("lw_ack_valid", 64'(l_rsp_valid), 64'd1);
    check("lw_ack_data", 64'(l_rsp_data), 64'd0);
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    f_req_valid = 1'b1;  // must not be granted during reset
    repeat (2) tick();
    #1;
    check("rst_f_ready", 64'(f_req_ready), 64'd0);
    check("rst_m_en", 64'(m_en), 64'd0);
    check("rst_f_rsp_valid", 64'(f_rsp_valid), 64'd0);
    check("rst_l_rsp_valid", 64'(l_rsp_valid), 64'd0);
    check("rst_l_rsp_data", 64'(l_rsp_data), 64'd0);
    reset = 1'b0;
    idle_inputs();
    tick();
    #1;
    check("idle_m_addr", 64'(m_addr), 64'd0);
    check("idle_m_wdata", 64'(m_wdata), 64'd0);
    tick();

    // Preload through the loader port.
    for (int i = 0; i < 4; i++) begin
      l_write(AW'(i), DW'(32'h13 + i));
      tick();
    end
    l_write(10'd8, 32'hA5A5_0008);
    tick();

    // F alone, addresses 0..3 back-to-back.
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        f_req_valid = 1'b1; f_addr = AW'(i);
      end else begin
        f_req_valid = 1'b0;
      end
      #1;
      if (i < 4) begin
        check("stream_ready", 64'(f_req_ready), 64'd1);
        check("stream_m_addr", 64'(m_addr), 64'(i));
      end
      if (i > 0) begin
        check("stream_rsp_valid", 64'(f_rsp_valid), 64'd1);
        check("stream_rsp_data", 64'(f_rsp_data), 64'(32'h13 + i - 1));
      end
      tick();
    end
    #1;
    check("stream_rsp_end", 64'(f_rsp_valid), 64'd0);
    tick();

    // Reset while a fetch response is in flight.
    f_req_valid = 1'b1; f_addr = 10'd0;
    tick();                     // addr 0 accepted
    f_addr = 10'd1;
    tick();                     // addr 1 accepted, response in flight
    reset = 1'b1;
    #1;
    check("midrst_rsp_dropped", 64'(f_rsp_valid), 64'd0);
    check("midrst_ready", 64'(f_req_ready), 64'd0);
    tick();
    #1;
    check("midrst_rsp_stays0", 64'(f_rsp_valid), 64'd0);
    reset = 1'b0;
    f_addr = 10'd2;
    #1;
    check("postrst_ready", 64'(f_req_ready), 64'd1);
    check("postrst_no_rsp", 64'(f_rsp_valid), 64'd0);
    tick();
    f_req_valid = 1'b0;
    #1;
    check("postrst_rsp_valid", 64'(f_rsp_valid), 64'd1);
    check("postrst_rsp_data", 64'(f_rsp_data), 64'h15);
    tick();

    // Loader write followed by fetch of the same address.
    l_write(10'd5, 32'hDEAD_BEEF);
    f_req_valid = 1'b1; f_addr = 10'd5;
    #1;
    check("wr_rd_f_ready", 64'(f_req_ready), 64'd1);
    tick();
    f_req_valid = 1'b0;
    #1;
    check("wr_rd_rsp_valid", 64'(f_rsp_valid), 64'd1);
    check("wr_rd_rsp_data", 64'(f_rsp_data), 64'hDEAD_BEEF);
    tick();

    // Both valid continuously: L,L,L,L,F repeating.
    f_req_valid = 1'b1; f_addr = 10'd0;
    l_req_valid = 1'b1; l_we = 1'b0; l_addr = 10'd1;
    for (int k = 0; k < 10; k++) begin
      #1;
      check("starve_f_ready", 64'(f_req_ready), 64'((k % 5) == 4));
      check("starve_l_ready", 64'(l_req_ready), 64'((k % 5) != 4));
      tick();
    end
    idle_inputs();
    tick();

    // Flush the cycle after an F grant.
    f_req_valid = 1'b1; f_addr = 10'd8;
    #1;
    check("flush_grant_n", 64'(f_req_ready), 64'd1);
    tick();
    f_flush = 1'b1;
    #1;
    check("flush_rsp_killed", 64'(f_rsp_valid), 64'd0);
    check("flush_no_grant", 64'(f_req_ready), 64'd0);
    check("flush_m_en", 64'(m_en), 64'd0);
    tick();
    f_flush = 1'b0;
    #1;
    check("flush_regrant", 64'(f_req_ready), 64'd1);
    check("flush_no_late_rsp", 64'(f_rsp_valid), 64'd0);
    tick();
    f_req_valid = 1'b0;
    #1;
    check("flush_regrant_valid", 64'(f_rsp_valid), 64'd1);
    check("flush_regrant_data", 64'(f_rsp_data), 64'hA5A5_0008);
    tick();

    // Loader read concurrent with flush.
    l_write(10'd3, 32'h1234_5678);
    f_req_valid = 1'b1; f_flush = 1'b1; f_addr = 10'd0;
    l_req_valid = 1'b1; l_we = 1'b0; l_addr = 10'd3;
    #1;
    check("lflush_l_ready", 64'(l_req_ready), 64'd1);
    check("lflush_f_ready", 64'(f_req_ready), 64'd0);
    check("lflush_m_we", 64'(m_we), 64'd0);
    tick();
    l_req_valid = 1'b0;
    #1;
    check("lflush_l_rsp_valid", 64'(l_rsp_valid), 64'd1);
    check("lflush_l_rsp_data", 64'(l_rsp_data), 64'h1234_5678);
    check("lflush_f_rsp_valid", 64'(f_rsp_valid), 64'd0);
    idle_inputs();
    tick();
    #1;
    check("final_l_rsp_valid", 64'(l_rsp_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
Two-requester arbiter that shares the single-port, synchronous-read instruction memory between the CPU fetch stage (port F, read-only) and the program loader/debug port (port L, read/write). It grants at most one request per cycle and drives the memory port. It returns each read response exactly one cycle after acceptance, steered to the owning requester. It sits between the fetch stage/loader and the instruction memory.

Parameters:
MEM_ADDR_WIDTH, 10, word address width of the memory and both request ports
INST_WIDTH, 32, instruction/data word width
STARVE_LIMIT, 4, consecutive lost arbitrations after which a pending fetch is forced to win (legal range 1..15)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
f_req_valid  input  1  fetch read request valid
f_req_ready  output  1  fetch request accepted this cycle
f_addr  input  MEM_ADDR_WIDTH  fetch word address
f_flush  input  1  kill in-flight fetch (branch/redirect)
f_rsp_valid  output  1  fetch response valid
f_rsp_data  output  INST_WIDTH  fetch response data
l_req_valid  input  1  loader request valid
l_req_ready  output  1  loader request accepted this cycle
l_we  input  1  1 = write, 0 = read
l_addr  input  MEM_ADDR_WIDTH  loader word address
l_wdata  input  INST_WIDTH  loader write data
l_rsp_valid  output  1  loader response/ack valid
l_rsp_data  output  INST_WIDTH  loader read data (0 for write acks)
m_en  output  1  memory access enable
m_we  output  1  memory write enable
m_addr  output  MEM_ADDR_WIDTH  memory address
m_wdata  output  INST_WIDTH  memory write data
m_rdata  input  INST_WIDTH  memory read data, valid the cycle after m_en

Behaviour:
- Reset (async): starve_cnt=0, pending owner tag cleared, kill flag 0. f_rsp_valid=l_rsp_valid=0, l_rsp_data=0. Requests present during reset are not granted. Responses in flight at reset are dropped and never reappear.
- Grant (combinational, one per cycle):
  - grant_f = f_req_valid & ~f_flush & (~l_req_valid | starve_cnt==STARVE_LIMIT).
  - grant_l = l_req_valid & ~grant_f.
  - f_req_ready=grant_f, l_req_ready=grant_l; a transfer occurs when valid & ready.
- Memory drive: m_en = grant_f|grant_l; m_we = grant_l & l_we. m_addr/m_wdata come from the granted port; m_wdata=0 when port F is granted. When idle, m_addr and m_wdata are 0.
- starve_cnt (4-bit, saturating at STARVE_LIMIT):
  - increments when f_req_valid & ~f_flush & grant_l;
  - clears on grant_f, or when f_req_valid=0;
  - holds while f_flush=1.
- Response pipeline (latency 1, throughput 1/cycle, no response backpressure):
  - The owner tag {F, L_read, L_write} is registered on grant.
  - Cycle after F grant: f_rsp_valid=1 and f_rsp_data=m_rdata, unless killed.
  - Cycle after L read: l_rsp_valid=1 and l_rsp_data=m_rdata.
  - Cycle after L write: l_rsp_valid=1 and l_rsp_data=0 (write ack).
  - f_rsp_data=m_rdata passes through combinationally and is don't-care when f_rsp_valid=0.
- Flush: f_flush=1 in cycle N means:
  - no fetch is granted in cycle N;
  - a fetch granted in cycle N-1 has its response suppressed in cycle N (f_rsp_valid forced 0 combinationally);
  - loader traffic is unaffected.
- Simultaneous requests with starve_cnt<STARVE_LIMIT: L wins.
- Loader write followed by fetch of the same address in the next cycle returns the new data (memory write-first ordering is sequential through the single port).

Optional Feature:
IMEM_ARB_PERF_EN:
- Defined: adds outputs perf_f_grants[31:0], perf_l_grants[31:0] and perf_f_stall[31:0].
  - perf_f_grants and perf_l_grants count transfers on each port.
  - perf_f_stall counts cycles with f_req_valid=1 and f_req_ready=0.
  - All three are wrapping counters, zeroed on reset, plus a synchronous input perf_clr that zeroes them the next cycle.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset mid-stream: F streaming reads, assert reset for 1 cycle while a response is in flight -> f_rsp_valid=0 from reset edge; the dropped response never appears; the first post-reset grant gives data one cycle later.
- F alone, addresses 0,1,2,3 back-to-back with mem preloaded 0x00000013+i -> f_req_ready=1 every cycle; f_rsp_data 0x13,0x14,0x15,0x16 on the following 4 consecutive cycles.
- L write 0xDEADBEEF to address 5, then F read address 5 the next cycle -> l_rsp_valid with l_rsp_data=0 the cycle after the write; f_rsp_data=0xDEADBEEF.
- F and L both valid continuously, STARVE_LIMIT=4 -> grant pattern L,L,L,L,F repeating; starve_cnt never exceeds 4.
- F read address 8 granted in cycle N, f_flush=1 in cycle N+1 with F still valid -> f_rsp_valid=0 in N+1; no F grant in N+1; F granted again in N+2.
- L read address 3 (value 0x12345678) concurrent with f_flush=1 -> L granted; l_rsp_valid=1 with 0x12345678 next cycle; f_rsp_valid stays 0.
